// File: rtl/retire_stage.sv
// In-order retire stage: commits up to three ROB entries per cycle, maintains the
// architectural map, returns superseded tags, and raises mispredict recovery / halt.
package retire_pkg;
  localparam int WAYS      = 3;
  localparam int ARCH_REGS = 32;
  localparam int ARW       = 5;
  localparam int PRW       = 6;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic             valid;
    logic             completed;
    logic [ARW-1:0]   arch_reg;
    logic [PRW-1:0]   Tnew;
    logic [PRW-1:0]   Told;
    logic             is_store;
    logic             halt;
    logic             precise_state_need;
    logic [XLEN-1:0]  target_pc;
  } rob_entry_t;
endpackage

module retire_stage
  import retire_pkg::*;
(
  input  logic                                 clock_i,
  input  logic                                 reset_i,
  input  rob_entry_t [WAYS-1:0]                retire_entry_i,
  output logic [WAYS-1:0]                      fl_return_valid_o,
  output logic [WAYS-1:0][PRW-1:0]             fl_return_preg_o,
  output logic [WAYS-1:0]                      sq_retire_o,
  output logic                                 BPRecoverEN_o,
  output logic [XLEN-1:0]                      recover_pc_o,
  output logic [ARCH_REGS-1:0][PRW-1:0]        arch_map_o,
  output logic [ARCH_REGS-1:0][PRW-1:0]        recover_map_o,
  output logic                                 halt_o,
  output logic [63:0]                          retired_cnt_o
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_SQUASH = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic [ARCH_REGS-1:0][PRW-1:0]  map_q, map_d;
  logic [63:0]                    cnt_q, cnt_d;
  logic [1:0]                     n_live;
  logic                           older_ok;
  logic                           halt_hit;
  logic                           recover;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PRW'(i);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      map_q   <= map_d;
    end
  end

  // Walk slots oldest (2) to youngest (0) so a younger write to the same
  // arch_reg overrides an older one; the chain breaks at the first gap,
  // halt or mispredict.
  always_comb begin
    fl_return_valid_o = '0;
    fl_return_preg_o  = '0;
    sq_retire_o       = '0;
    recover           = 1'b0;
    recover_pc_o      = '0;
    halt_hit          = 1'b0;
    n_live            = '0;
    map_d             = map_q;
    older_ok          = (state_q == S_RUN) && !reset_i;
    for (int k = WAYS - 1; k >= 0; k--) begin
      if (older_ok && retire_entry_i[k].valid && retire_entry_i[k].completed) begin
        n_live         = n_live + 2'd1;
        sq_retire_o[k] = retire_entry_i[k].is_store;
        if (retire_entry_i[k].arch_reg != '0) begin
          fl_return_valid_o[k]                = 1'b1;
          fl_return_preg_o[k]                 = retire_entry_i[k].Told;
          map_d[retire_entry_i[k].arch_reg]   = retire_entry_i[k].Tnew;
        end
        if (retire_entry_i[k].halt) begin
          halt_hit = 1'b1;
          older_ok = 1'b0;
        end else if (retire_entry_i[k].precise_state_need) begin
          recover      = 1'b1;
          recover_pc_o = retire_entry_i[k].target_pc;
          older_ok     = 1'b0;
        end
      end else begin
        older_ok = 1'b0;
      end
    end

    cnt_d = cnt_q + {62'd0, n_live};

    state_d = state_q;
    unique case (state_q)
      S_RUN:    if (halt_hit) state_d = S_HALTED;
                else if (recover) state_d = S_SQUASH;
      S_SQUASH: state_d = S_RUN;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase
  end

  assign BPRecoverEN_o = recover;
  assign recover_map_o = (reset_i || state_q == S_HALTED) ? '0 : map_d;
  assign arch_map_o    = map_q;
  assign retired_cnt_o = cnt_q;
  assign halt_o        = (state_q == S_HALTED);

endmodule

// File: tb/tb_retire_stage.sv
// Directed bench for retire_stage: stimulus pushes expected strobes into a queue,
// a negedge monitor pops and compares whenever the DUT shows retire activity.
module tb_retire_stage;
  import retire_pkg::*;

  logic                           clk;
  logic                           rst;
  rob_entry_t [WAYS-1:0]          ent;
  logic [WAYS-1:0]                flv;
  logic [WAYS-1:0][PRW-1:0]       preg;
  logic [WAYS-1:0]                sq;
  logic                           bp;
  logic [XLEN-1:0]                rpc;
  logic [ARCH_REGS-1:0][PRW-1:0]  amap;
  logic [ARCH_REGS-1:0][PRW-1:0]  rmap;
  logic                           hlt;
  logic [63:0]                    rcnt;

  retire_stage dut (
    .clock_i           (clk),
    .reset_i           (rst),
    .retire_entry_i    (ent),
    .fl_return_valid_o (flv),
    .fl_return_preg_o  (preg),
    .sq_retire_o       (sq),
    .BPRecoverEN_o     (bp),
    .recover_pc_o      (rpc),
    .arch_map_o        (amap),
    .recover_map_o     (rmap),
    .halt_o            (hlt),
    .retired_cnt_o     (rcnt)
  );

  typedef struct packed {
    logic [2:0]      flv;
    logic [2:0][5:0] preg;
    logic [2:0]      sq;
    logic            bp;
    logic [31:0]     pc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic rob_entry_t mk(input logic v, input logic c, input int ar, input int tn,
                                    input int to, input logic st, input logic h, input logic psn,
                                    input logic [31:0] pc);
    rob_entry_t e;
    e.valid              = v;
    e.completed          = c;
    e.arch_reg           = ARW'(ar);
    e.Tnew               = PRW'(tn);
    e.Told               = PRW'(to);
    e.is_store           = st;
    e.halt               = h;
    e.precise_state_need = psn;
    e.target_pc          = pc;
    return e;
  endfunction

  function automatic exp_t mkexp(input logic [2:0] f, input int p2, input int p1, input int p0,
                                 input logic [2:0] s, input logic b, input logic [31:0] pc);
    exp_t x;
    x.flv     = f;
    x.preg[2] = 6'(p2);
    x.preg[1] = 6'(p1);
    x.preg[0] = 6'(p0);
    x.sq      = s;
    x.bp      = b;
    x.pc      = pc;
    return x;
  endfunction

  rob_entry_t idle_e;

  task automatic drive(input rob_entry_t e2, input rob_entry_t e1, input rob_entry_t e0);
    @(posedge clk);
    #1;
    ent[2] = e2;
    ent[1] = e1;
    ent[0] = e0;
  endtask

  task automatic idle();
    drive(idle_e, idle_e, idle_e);
  endtask

  always @(negedge clk) begin
    if (!rst && (flv != 3'b000 || sq != 3'b000 || bp)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: flv=%b sq=%b bp=%b expected none", flv, sq, bp);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("mon_flv", 64'(flv), 64'(x.flv));
        chk("mon_sq", 64'(sq), 64'(x.sq));
        chk("mon_bp", 64'(bp), 64'(x.bp));
        if (x.bp) chk("mon_pc", 64'(rpc), 64'(x.pc));
        for (int k = 0; k < 3; k++)
          if (x.flv[k]) chk($sformatf("mon_preg%0d", k), 64'(preg[k]), 64'(x.preg[k]));
      end
    end
  end

  initial begin
    idle_e = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    ent    = {idle_e, idle_e, idle_e};
    rst    = 1'b1;
    #3;
    chk("rst_map5", 64'(amap[5]), 64'd5);
    chk("rst_cnt", rcnt, 64'd0);
    chk("rst_halt", 64'(hlt), 64'd0);
    #5 rst = 1'b0;

    // triple commit
    drive(mk(1, 1, 3, 40, 3, 0, 0, 0, 0), mk(1, 1, 0, 9, 9, 0, 0, 0, 0), mk(1, 1, 7, 41, 7, 1, 0, 0, 0));
    exp_q.push_back(mkexp(3'b101, 3, 0, 7, 3'b001, 0, 0));
    idle();
    chk("tri_map3", 64'(amap[3]), 64'd40);
    chk("tri_map7", 64'(amap[7]), 64'd41);
    chk("tri_cnt", rcnt, 64'd3);

    // same-register WAW
    drive(mk(1, 1, 4, 50, 4, 0, 0, 0, 0), mk(1, 1, 4, 51, 50, 0, 0, 0, 0), idle_e);
    exp_q.push_back(mkexp(3'b110, 4, 50, 0, 3'b000, 0, 0));
    idle();
    chk("waw_map4", 64'(amap[4]), 64'd51);
    chk("waw_cnt", rcnt, 64'd5);

    // mispredict in slot 1
    drive(mk(1, 1, 1, 20, 1, 0, 0, 0, 0), mk(1, 1, 2, 21, 2, 0, 0, 1, 32'h1000),
          mk(1, 1, 3, 22, 40, 0, 0, 0, 0));
    exp_q.push_back(mkexp(3'b110, 1, 2, 0, 3'b000, 1, 32'h1000));
    #2;
    chk("mp_rmap2", 64'(rmap[2]), 64'd21);
    chk("mp_rmap3", 64'(rmap[3]), 64'd40);
    drive(mk(1, 1, 5, 30, 5, 0, 0, 0, 0), idle_e, idle_e);
    chk("mp_map1", 64'(amap[1]), 64'd20);
    chk("mp_map3", 64'(amap[3]), 64'd40);
    chk("mp_cnt", rcnt, 64'd7);
    drive(mk(1, 1, 5, 30, 5, 0, 0, 0, 0), idle_e, idle_e);
    exp_q.push_back(mkexp(3'b100, 5, 0, 0, 3'b000, 0, 0));
    idle();
    chk("post_sq_map5", 64'(amap[5]), 64'd30);
    chk("post_sq_cnt", rcnt, 64'd8);

    // gaps: incomplete oldest, then invalid oldest
    drive(mk(1, 0, 6, 31, 6, 0, 0, 0, 0), mk(1, 1, 6, 32, 6, 1, 0, 0, 0), idle_e);
    drive(idle_e, mk(1, 1, 6, 33, 6, 1, 0, 0, 0), mk(1, 1, 6, 34, 6, 0, 0, 0, 0));
    idle();
    chk("gap_cnt", rcnt, 64'd8);
    chk("gap_map6", 64'(amap[6]), 64'd6);

    // halt in slot 2
    drive(mk(1, 1, 8, 33, 8, 0, 1, 0, 0), mk(1, 1, 9, 34, 9, 0, 0, 0, 0), mk(1, 1, 10, 35, 10, 1, 0, 0, 0));
    exp_q.push_back(mkexp(3'b100, 8, 0, 0, 3'b000, 0, 0));
    chk("halt_not_yet", 64'(hlt), 64'd0);
    drive(mk(1, 1, 11, 36, 11, 1, 0, 0, 0), mk(1, 1, 12, 37, 12, 0, 0, 1, 32'h40), idle_e);
    chk("halt_set", 64'(hlt), 64'd1);
    chk("halt_cnt", rcnt, 64'd9);
    chk("halt_map8", 64'(amap[8]), 64'd33);
    chk("halt_map9", 64'(amap[9]), 64'd9);
    idle();
    chk("halt_frozen_cnt", rcnt, 64'd9);
    chk("halt_sticky", 64'(hlt), 64'd1);

    // async reset mid-cycle, no edge between assert and check
    ent[2] = mk(1, 1, 13, 38, 13, 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("mrst_map5", 64'(amap[5]), 64'd5);
    chk("mrst_map8", 64'(amap[8]), 64'd8);
    chk("mrst_cnt", rcnt, 64'd0);
    chk("mrst_halt", 64'(hlt), 64'd0);
    chk("mrst_flv", 64'(flv), 64'd0);
    chk("mrst_sq", 64'(sq), 64'd0);
    @(posedge clk);
    #1;
    ent = {idle_e, idle_e, idle_e};
    rst = 1'b0;

    // halt and mispredict in the same slot: halt wins
    drive(mk(1, 1, 12, 60, 12, 0, 1, 1, 32'h2000), mk(1, 1, 14, 61, 14, 0, 0, 0, 0), idle_e);
    exp_q.push_back(mkexp(3'b100, 12, 0, 0, 3'b000, 0, 0));
    idle();
    chk("hp_halt", 64'(hlt), 64'd1);
    chk("hp_cnt", rcnt, 64'd1);
    chk("hp_map12", 64'(amap[12]), 64'd60);

    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
